// File: rtl/load_store_unit.sv
// Byte/halfword/word load-store unit in front of a single-port word RAM.
// Sub-word stores are done as read-modify-write; misaligned requests complete with addr_err.
module load_store_unit #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic        addr_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0] OP_LW = 3'd0, OP_LB = 3'd1, OP_LBU = 3'd2, OP_LH = 3'd3,
                         OP_LHU = 3'd4, OP_SW = 3'd5, OP_SB = 3'd6, OP_SH = 3'd7;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q;
  logic [31:0] addr_q;
  logic [15:0] wdata_q;
  logic [3:0]  cnt_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [31:0] mem_wdata_q;
  logic        misaligned;
  logic [31:0] load_val;
  logic [31:0] merged;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Alignment is judged on the live request since it only matters in the start cycle
  always_comb begin
    misaligned = 1'b0;
    case (op)
      OP_LW, OP_SW:          misaligned = (addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH:  misaligned = addr[0];
      default:               misaligned = 1'b0;
    endcase
  end

  always_comb begin
    byte_sel = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (op_q)
      OP_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_val = {24'd0, byte_sel};
      OP_LH:   load_val = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_val = {16'd0, half_sel};
      default: load_val = mem_rdata;
    endcase
  end

  always_comb begin
    merged = mem_rdata;
    if (op_q == OP_SB) merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else               merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:
        if (start) begin
          if (misaligned)       state_d = DONE;
          else if (op == OP_SW) state_d = WRITE;
          else                  state_d = READ;
        end
      READ:
        if (cnt_q == 4'd0) state_d = (op_q == OP_SB || op_q == OP_SH) ? WRITE : DONE;
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= OP_LW;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE:
          if (start) begin
            op_q    <= op;
            addr_q  <= addr;
            wdata_q <= wdata[15:0];
            err_q   <= misaligned;
            cnt_q   <= 4'(MEM_WAIT);
            if (op == OP_SW && !misaligned) mem_wdata_q <= wdata;
          end
        READ:
          if (cnt_q == 4'd0) begin
            // Last read edge: loads finish here, sub-word stores build their write word
            if (op_q == OP_SB || op_q == OP_SH) mem_wdata_q <= merged;
            else                                rdata_q     <= load_val;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        default: ;
      endcase
    end
  end

  assign done      = (state_q == DONE);
  assign addr_err  = done & err_q;
  assign rdata     = rdata_q;
  assign mem_read  = (state_q == READ);
  assign mem_write = (state_q == WRITE);
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: reference model of RAM and last load result,
// one DUT with MEM_WAIT=0 for directed+random traffic and one with MEM_WAIT=3.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start0, done0, err0, mrd0, mwr0;
  logic [2:0]  op0;
  logic [31:0] addr0, wdata0, rdata0, maddr0, mwdata0, mrdata0;
  logic        start3, done3, err3, mrd3, mwr3;
  logic [2:0]  op3;
  logic [31:0] addr3, wdata3, rdata3, maddr3, mwdata3, mrdata3;

  load_store_unit #(.MEM_WAIT(0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .op(op0), .addr(addr0), .wdata(wdata0),
    .done(done0), .rdata(rdata0), .addr_err(err0), .mem_addr(maddr0), .mem_wdata(mwdata0),
    .mem_read(mrd0), .mem_write(mwr0), .mem_rdata(mrdata0));

  load_store_unit #(.MEM_WAIT(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .op(op3), .addr(addr3), .wdata(wdata3),
    .done(done3), .rdata(rdata3), .addr_err(err3), .mem_addr(maddr3), .mem_wdata(mwdata3),
    .mem_read(mrd3), .mem_write(mwr3), .mem_rdata(mrdata3));

  logic [31:0] mem0 [256];
  logic [31:0] mem3 [256];
  assign mrdata0 = mem0[maddr0[9:2]];
  assign mrdata3 = mem3[maddr3[9:2]];
  always @(posedge clk) if (mwr0) mem0[maddr0[9:2]] <= mwdata0;
  always @(posedge clk) if (mwr3) mem3[maddr3[9:2]] <= mwdata3;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    int          t0;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  logic [31:0] refmem [256];
  logic [31:0] last_rd;
  int checks = 0, errors = 0, cyc = 0;
  int nrd = 0, nwr = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain arithmetic on a word array, returns what the bus and result should show
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] w,
                       input int mw, output exp_t e);
    int unsigned idx, bsh, hsh;
    logic [31:0] word, bv, hv, r;
    bit mis;
    idx  = a[9:2];
    bsh  = 8 * a[1:0];
    hsh  = 16 * a[1];
    word = refmem[idx];
    mis  = ((o == 0 || o == 5) && a[1:0] != 0) || ((o == 3 || o == 4 || o == 7) && a[0]);
    e = '{rdata: last_rd, err: 1'b0, lat: 0, nrd: 0, nwr: 0, t0: 0};
    if (mis) begin
      e.err = 1'b1; e.lat = 1;
      return;
    end
    bv = (word >> bsh) & 32'hFF;
    hv = (word >> hsh) & 32'hFFFF;
    r  = word;
    case (o)
      1: r = (bv >= 128) ? bv - 32'd256 : bv;
      2: r = bv;
      3: r = (hv >= 32768) ? hv - 32'd65536 : hv;
      4: r = hv;
      default: r = word;
    endcase
    if (o <= 4) begin
      last_rd = r; e.rdata = r; e.lat = 2 + mw; e.nrd = mw + 1;
    end else if (o == 5) begin
      refmem[idx] = w; e.lat = 2; e.nwr = 1;
    end else begin
      if (o == 6) refmem[idx] = (word & ~(32'hFF << bsh)) | ((w & 32'hFF) << bsh);
      else        refmem[idx] = (word & ~(32'hFFFF << hsh)) | ((w & 32'hFFFF) << hsh);
      e.lat = 3 + mw; e.nrd = mw + 1; e.nwr = 1;
    end
  endtask

  // Monitor: pops the scoreboard on every done from dut0
  always @(negedge clk) begin
    if (reset) begin
      nrd = 0; nwr = 0;
    end else if (mon_en) begin
      if (mrd0 && mwr0) begin
        errors++;
        $display("FAIL strobes: mem_read and mem_write both high (t=%0t)", $time);
      end
      nrd += int'(mrd0);
      nwr += int'(mwr0);
      if (done0) begin
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: got done=1 expected none (t=%0t)", $time);
        end else begin
          mon_e = sbq.pop_front();
          chk("rdata", rdata0, mon_e.rdata);
          chk("addr_err", {31'd0, err0}, {31'd0, mon_e.err});
          chk("latency", cyc - mon_e.t0, mon_e.lat);
          chk("mem_read_cycles", nrd, mon_e.nrd);
          chk("mem_write_cycles", nwr, mon_e.nwr);
        end
        nrd = 0; nwr = 0;
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] w, input bit hold);
    exp_t e;
    bit seen;
    model(o, a, w, 0, e);
    e.t0 = cyc;
    sbq.push_back(e);
    op0 = o; addr0 = a; wdata0 = w; start0 = 1'b1;
    @(posedge clk); #1;
    if (!hold) start0 = 1'b0;
    op0 = 3'($urandom); addr0 = $urandom; wdata0 = $urandom;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = done0;
    end
    start0 = 1'b0;
    if (!seen) begin
      checks++; errors++;
      $display("FAIL timeout: got no done expected done for op %0d addr %h", o, a);
      sbq.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    bit seen;
    int t0, rd3, wr3;
    logic [7:0] same_b;
    for (int i = 0; i < 256; i++) begin
      mem0[i] = $urandom; refmem[i] = mem0[i]; mem3[i] = 32'd0;
    end
    mem0[8'h40] = 32'h11223344; refmem[8'h40] = 32'h11223344;
    mem3[8'h40] = 32'hCAFEF00D;
    last_rd = 32'd0;
    reset = 1'b1;
    start0 = 0; op0 = 0; addr0 = 0; wdata0 = 0;
    start3 = 0; op3 = 0; addr3 = 0; wdata3 = 0;
    repeat (3) @(negedge clk);
    chk("rst_done", {31'd0, done0}, 32'd0);
    chk("rst_addr_err", {31'd0, err0}, 32'd0);
    chk("rst_rdata", rdata0, 32'd0);
    chk("rst_mem_addr", maddr0, 32'd0);
    chk("rst_mem_wdata", mwdata0, 32'd0);
    chk("rst_strobes", {30'd0, mrd0, mwr0}, 32'd0);
    reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    issue(3'd0, 32'h100, 32'h0, 0);  chk("lw_0x100", rdata0, 32'h11223344);
    issue(3'd1, 32'h103, 32'h0, 0);  chk("lb_0x103", rdata0, 32'h00000011);
    issue(3'd5, 32'h100, 32'h80000000, 0);
    issue(3'd3, 32'h102, 32'h0, 0);  chk("lh_0x102", rdata0, 32'hFFFF8000);
    issue(3'd4, 32'h102, 32'h0, 0);  chk("lhu_0x102", rdata0, 32'h00008000);
    issue(3'd5, 32'h104, 32'hAABBCCDD, 0);
    issue(3'd6, 32'h105, 32'h000000EE, 0);
    chk("sb_ram", mem0[8'h41], 32'hAABBEEDD);
    issue(3'd0, 32'h104, 32'h0, 1);  chk("lw_after_sb", rdata0, 32'hAABBEEDD);
    issue(3'd0, 32'h102, 32'h0, 0);  chk("lw_mis_rdata_kept", rdata0, 32'hAABBEEDD);
    issue(3'd7, 32'h101, 32'h1234, 0); chk("sh_mis_ram_kept", mem0[8'h40], 32'h80000000);

    // Reset during the write cycle of a byte store that rewrites the same byte value
    same_b = refmem[8'h80][15:8];
    op0 = 3'd6; addr0 = 32'h201; wdata0 = {24'd0, same_b}; start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = mwr0;
    end
    chk("rst_test_reached_write", {31'd0, seen}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_mem_write", {31'd0, mwr0}, 32'd0);
    chk("abort_done", {31'd0, done0}, 32'd0);
    chk("abort_rdata", rdata0, 32'd0);
    chk("abort_mem_addr", maddr0, 32'd0);
    chk("abort_mem_wdata", mwdata0, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    last_rd = 32'd0;
    repeat (3) @(negedge clk);

    repeat (300)
      issue(3'($urandom_range(0, 7)), 32'($urandom_range(0, 1023)), $urandom, $urandom_range(0, 3) == 0);

    // MEM_WAIT=3: start held through the whole operation, other request on the inputs
    t0 = cyc; rd3 = 0; wr3 = 0;
    op3 = 3'd0; addr3 = 32'h100; start3 = 1'b1;
    @(posedge clk); #1;
    op3 = 3'd5; addr3 = 32'h104; wdata3 = $urandom;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      rd3 += int'(mrd3); wr3 += int'(mwr3);
      seen = done3;
    end
    chk("w3_latency", cyc - t0, 5);
    chk("w3_read_cycles", rd3, 4);
    chk("w3_rdata", rdata3, 32'hCAFEF00D);
    chk("w3_addr_err", {31'd0, err3}, 32'd0);
    @(posedge clk); #1; start3 = 1'b0;
    rd3 = 0;
    repeat (6) begin
      @(negedge clk);
      rd3 += int'(mrd3); wr3 += int'(mwr3);
      if (done3) rd3 += 100;
    end
    chk("w3_no_queued_op", rd3, 0);
    chk("w3_no_write", wr3, 0);

    for (int i = 0; i < 256; i++) chk("ram_final", mem0[i], refmem[i]);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
